data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 64-bit doublewords stored; power of two.
REQ-002 Parameter LATENCY, default 2: number of BUSY cycles per access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Mem_Read  input  1  EX/MEM-stage load request.
REQ-006 Mem_Write  input  1  EX/MEM-stage store request.
REQ-007 Address  input  64  byte address from EX/MEM (ALU result).
REQ-008 Write_Data  input  64  store data from EX/MEM.
REQ-009 Read_Data  output  64  load data toward MEM/WB Read_Data input.
REQ-010 Read_Valid  output  1  one-cycle pulse: Read_Data holds new load result.
REQ-011 Mem_Stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM while high.
REQ-012 Misaligned  output  1  one-cycle pulse: request rejected, Address[2:0] != 0.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; any unused encoding SHALL return to IDLE.
REQ-014 Request = Mem_Read | Mem_Write sampled in IDLE; aligned = (Address[2:0] == 3'b000).
REQ-015 IDLE + aligned request: capture Address, Write_Data and op type; load cycle counter with LATENCY-1; go to BUSY.
REQ-016 IDLE + misaligned request: Misaligned = 1 for the next cycle; no memory access; state stays IDLE; Mem_Stall stays 0.
REQ-017 BUSY: counter decrements each cycle; at count 0 go to DONE; BUSY lasts exactly LATENCY cycles.
REQ-018 Write commits to array[captured_Address[3+log2(DEPTH_WORDS)-1:3]] on the BUSY-to-DONE edge.
REQ-019 Read: Read_Data registered from array at the BUSY-to-DONE edge; Read_Valid = 1 during DONE only.
REQ-020 DONE always returns to IDLE the next cycle; a new request is accepted no earlier than the cycle after DONE.
REQ-021 Mem_Stall = (IDLE & aligned request) | BUSY; combinational; 0 in DONE, so the pipeline advances at the DONE edge.
REQ-022 Total stall per aligned access = LATENCY+1 cycles; the pipeline holds the request inputs stable throughout.
REQ-023 Mem_Read and Mem_Write both high: treat as write only; no Read_Valid pulse; Read_Data unchanged.
REQ-024 Upper address bits beyond the index field SHALL be ignored; accesses wrap modulo DEPTH_WORDS.
REQ-025 Read_Data SHALL hold its last value until the next completed read.
REQ-026 Inputs changing during BUSY SHALL be ignored; only captured values are used.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, counter 0, Read_Data 64'b0, Read_Valid 0, Misaligned 0, captured registers 0.
REQ-028 Mem_Stall SHALL evaluate to 0 during reset regardless of request inputs.
REQ-029 Reset asserted during BUSY SHALL abort the access; the pending write SHALL NOT commit.
REQ-030 Reset SHALL NOT clear the memory array contents.
REQ-031 After reset deassertion, the first rising edge with an aligned request starts a new access.

Verification
REQ-032 LATENCY=2; write 64'hDEAD_BEEF_0123_4567 to 0x10, then read 0x10 -> Mem_Stall high 3 cycles per access; Read_Valid pulses 1 cycle; Read_Data = 64'hDEAD_BEEF_0123_4567.
REQ-033 Read at Address 0x13 -> Misaligned pulses 1 cycle; Mem_Stall stays 0; Read_Data unchanged.
REQ-034 DEPTH_WORDS=64: write 64'h1 to 0x208, read 0x008 -> Read_Data = 64'h1 (wrap).
REQ-035 Mem_Read = Mem_Write = 1 at 0x20 with data 64'h55 -> no Read_Valid; a later read of 0x20 returns 64'h55.
REQ-036 Write 64'hAA to 0x30, then write 64'hBB to 0x30 with reset pulsed low during BUSY -> outputs zero immediately; a later read of 0x30 returns 64'hAA.
REQ-037 Back-to-back reads of 0x00 and 0x08 with inputs changed mid-BUSY -> each result matches its captured address; the second access starts only after DONE.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller for the MEM stage.
// An aligned load/store is captured in IDLE, held for LATENCY BUSY cycles,
// completed on the BUSY-to-DONE edge, and reported during the single DONE
// cycle. Mem_Stall freezes the upstream pipeline until DONE.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [63:0] Address,
  input  logic [63:0] Write_Data,
  output logic [63:0] Read_Data,
  output logic        Read_Valid,
  output logic        Mem_Stall,
  output logic        Misaligned
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      idx_q;
  logic [63:0]        wdata_q;
  logic               is_write_q;
  logic [63:0]        rdata_q;
  logic               rvalid_q;
  logic               mis_q, mis_d;
  logic               accept;
  logic               finish;
  logic               req;
  logic               aligned;
  logic [63:0]        mem [DEPTH_WORDS];

  // Address bits above the word index are deliberately dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[63:3+AW];

  assign req     = Mem_Read | Mem_Write;
  assign aligned = (Address[2:0] == 3'b000);

  // State and cycle-counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus the accept/finish strobes that drive the datapath.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            accept  = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture, load result, and the one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      mis_q    <= mis_d;
      rvalid_q <= finish & ~is_write_q;
      if (accept) begin
        idx_q      <= Address[3 +: AW];
        wdata_q    <= Write_Data;
        is_write_q <= Mem_Write;
      end
      if (finish && !is_write_q) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // Storage array write port; commits only on the BUSY-to-DONE edge.
  // NOTE: the array has no reset branch on purpose: contents survive reset,
  // and a reset during BUSY forces state_q to IDLE so finish cannot fire.
  always_ff @(posedge clk) begin
    if (finish && is_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Stall is combinational so the pipeline freezes in the request cycle itself.
  assign Mem_Stall  = reset & (((state_q == IDLE) & req & aligned) | (state_q == BUSY));
  assign Read_Data  = rdata_q;
  assign Read_Valid = rvalid_q;
  assign Misaligned = mis_q;

endmodule
